adc_spi_responder: RTL and testbench

ADC_SPI_RESPONDER -- requirements
Module: adc_spi_responder

---
 rtl/adc_spi_responder_pkg.sv | 21 ++
 rtl/adc_spi_responder_sync.sv | 28 ++
 rtl/adc_spi_responder.sv | 143 ++++++++++++++
 tb/tb_adc_spi_responder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/adc_spi_responder_pkg.sv
// adc_spi_responder_pkg
// Shared constants and the FSM state type for the emulated SPI ADC.
// The frame is 16 sclk periods long. A frame starts with 4 zero bits,
// followed by the conversion value, MSB first. The channel address for the
// next frame is captured on the rising edges with bit counts 2 to 4.
package adc_spi_responder_pkg;

  localparam int FRAME_LEN  = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int CNT_W      = 4;

  // Bit-counter values are typed to the counter width so compares stay width-clean
  localparam logic [CNT_W-1:0] ADDR_BIT_FIRST = 4'd2;
  localparam logic [CNT_W-1:0] ADDR_BIT_LAST  = 4'd4;
  localparam logic [CNT_W-1:0] LAST_BIT       = 4'd15;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_ACTIVE = 1'b1;

endpackage

// File: rtl/adc_spi_responder_sync.sv
// sync_2ff
// Two-flop synchronizer that brings one asynchronous input into the clk domain.
// Ports:
//   clk, rst_n : system clock and asynchronous active-low reset
//   d          : asynchronous input
//   q          : synchronized output, held at RESET_VAL while in reset
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_spi_responder.sv
// adc_spi_responder
// Emulates a multi-channel SPI ADC in the same way as an ADC128S-style part.
// Each 16-bit frame returns the channel that was addressed in the previous
// frame. The frame holds 4 leading zeros, followed by DATA_W bits, MSB first.
// The address is taken from din on the rising edges with bit counts 2 to 4.
// Ports:
//   clk, rst_n  : system clock (at least 8x sclk) and async active-low reset
//   sclk, cs_n  : SPI clock and chip select from the master (async to clk)
//   din         : serial address from the master
//   dout        : serial conversion data to the master (0 when not selected)
//   ch_data     : packed channel values, channel k at [k*DATA_W +: DATA_W]
//   frame_done  : one-clk pulse when a full 16-bit frame completes
//   cur_ch      : channel returned by the current or next frame
module adc_spi_responder
  import adc_spi_responder_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sclk,
  input  logic                     cs_n,
  input  logic                     din,
  output logic                     dout,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic                     frame_done,
  output logic [ADDR_W-1:0]        cur_ch
);

  logic sclk_s, cs_s, din_s;
  logic sclk_q, cs_q;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic [1:0] warm;
  logic armed;

  state_t               state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [FRAME_LEN-1:0] shreg;
  logic [ADDR_W-1:0]    pend;
  logic                 reload;
  logic [DATA_W-1:0]    sel_data;
  logic [FRAME_LEN-1:0] load_word;

  sync_2ff #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_s));
  sync_2ff #(.RESET_VAL(1'b0)) u_sync_din  (.clk(clk), .rst_n(rst_n), .d(din),  .q(din_s));

  assign sclk_rise = ~sclk_q &  sclk_s;
  assign sclk_fall =  sclk_q & ~sclk_s;
  assign cs_rise   = ~cs_q   &  cs_s;
  assign cs_fall   =  cs_q   & ~cs_s;

  // The cs_n synchronizer resets high, so it can show a false falling edge
  // when reset is released with cs_n already low. The warm-up shift waits
  // until the synchronizer output is real. After that, chip select has to be
  // seen high before a falling edge may start a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_q <= 1'b0;
      cs_q   <= 1'b1;
      warm   <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sclk_q <= sclk_s;
      cs_q   <= cs_s;
      warm   <= {warm[0], 1'b1};
      if (warm[1] && cs_s)
        armed <= 1'b1;
    end
  end

  // Channel mux. An address with no matching channel returns zero.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (cur_ch == ADDR_W'(k))
        sel_data = ch_data[k*DATA_W +: DATA_W];
  end

  // Zero extension provides the leading-zero bits of the frame
  assign load_word = FRAME_LEN'(sel_data);

  // Frame FSM. A cs_n edge is checked first, so an sclk edge detected in the
  // same cycle is dropped. cur_ch changes only at the end of a frame, so an
  // aborted frame leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      pend       <= '0;
      cur_ch     <= '0;
      frame_done <= 1'b0;
      reload     <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cs_fall && armed) begin
            state   <= ST_ACTIVE;
            bit_cnt <= '0;
            shreg   <= load_word;
            pend    <= '0;
            reload  <= 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (cs_rise) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            pend    <= '0;
            reload  <= 1'b0;
          end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt >= ADDR_BIT_FIRST && bit_cnt <= ADDR_BIT_LAST)
              pend <= {pend[ADDR_W-2:0], din_s};
            // The next falling edge starts the following frame in continuous mode
            if (bit_cnt == LAST_BIT) begin
              frame_done <= 1'b1;
              cur_ch     <= pend;
              reload     <= 1'b1;
            end
          end else if (sclk_fall) begin
            if (reload) begin
              shreg  <= load_word;
              reload <= 1'b0;
            end else begin
              shreg <= {shreg[FRAME_LEN-2:0], 1'b0};
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The shift register is cleared in IDLE, so dout is 0 when not selected
  assign dout = shreg[FRAME_LEN-1];

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb_adc_spi_responder
// Directed bench for adc_spi_responder. clk runs at 8 MHz and sclk at 1 MHz.
// Each sclk phase lasts 4 clk periods. dout is sampled on a clk falling edge,
// just before each sclk rising edge.
`timescale 1ns/100ps
module tb_adc_spi_responder;

  localparam int NUM_CH = 8;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic rst_n, sclk, cs_n, din, dout, frame_done;
  logic [NUM_CH*DATA_W-1:0] ch_data;
  logic [ADDR_W-1:0] cur_ch;

  int compared = 0;
  int mismatched = 0;
  int fd_count = 0;
  int fd_mark;
  logic [15:0] rx;

  adc_spi_responder #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .din(din),
    .dout(dout), .ch_data(ch_data), .frame_done(frame_done), .cur_ch(cur_ch)
  );

  always #62.5 clk = ~clk;

  // Count every clk cycle in which frame_done is high
  always @(negedge clk) if (frame_done === 1'b1) fd_count++;

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, required %h", tag, got, exp);
    end
  endtask

  task automatic setCh(input int k, input logic [DATA_W-1:0] v);
    ch_data[k*DATA_W +: DATA_W] = v;
  endtask

  task automatic csLow();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic csHigh();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // Runs nbits sclk periods. din_bits is sent MSB first. Bit i of the frame
  // is returned in dout_bits[15-i]. When the loop reaches bit chg_at, channel
  // 0 is set to chg_val.
  task automatic applyStimulus(input logic [15:0] din_bits, input int nbits,
                               input int chg_at, input logic [DATA_W-1:0] chg_val,
                               output logic [15:0] dout_bits);
    dout_bits = '0;
    for (int i = 0; i < nbits; i++) begin
      din = din_bits[15-i];
      if (i == chg_at) setCh(0, chg_val);
      repeat (4) @(negedge clk);
      dout_bits[15-i] = dout;
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; din = 1'b0; ch_data = '0;
    setCh(0, 12'hABC); setCh(1, 12'h1A1); setCh(2, 12'h2C3); setCh(3, 12'h3FF);
    setCh(4, 12'h4B4); setCh(5, 12'h5A5); setCh(6, 12'h666); setCh(7, 12'h7E1);

    repeat (3) @(negedge clk);
    checkOutput("reset_dout", 32'(dout), 32'd0);
    checkOutput("reset_frame_done", 32'(frame_done), 32'd0);
    checkOutput("reset_cur_ch", 32'(cur_ch), 32'd0);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // Basic read of channel 0
    fd_mark = fd_count;
    csLow(); applyStimulus(16'h0000, 16, -1, '0, rx); csHigh();
    checkOutput("basic_dout", 32'(rx), 32'h0ABC);
    checkOutput("basic_frame_done", 32'(fd_count - fd_mark), 32'd1);
    checkOutput("basic_cur_ch", 32'(cur_ch), 32'd0);
    checkOutput("idle_dout", 32'(dout), 32'd0);

    // Address channel 5, then read it back in the next frame
    fd_mark = fd_count;
    csLow(); applyStimulus(16'h2800, 16, -1, '0, rx); csHigh();
    checkOutput("addr_f1_dout", 32'(rx), 32'h0ABC);
    checkOutput("addr_f1_cur_ch", 32'(cur_ch), 32'd5);
    csLow(); applyStimulus(16'h0000, 16, -1, '0, rx); csHigh();
    checkOutput("addr_f2_dout", 32'(rx), 32'h05A5);
    checkOutput("addr_f2_cur_ch", 32'(cur_ch), 32'd0);
    checkOutput("addr_frame_done", 32'(fd_count - fd_mark), 32'd2);

    // Abort after 8 sclk while addressing channel 6
    fd_mark = fd_count;
    csLow(); applyStimulus(16'h3000, 8, -1, '0, rx); csHigh();
    checkOutput("abort_frame_done", 32'(fd_count - fd_mark), 32'd0);
    checkOutput("abort_cur_ch", 32'(cur_ch), 32'd0);
    csLow(); applyStimulus(16'h0000, 16, -1, '0, rx); csHigh();
    checkOutput("abort_next_dout", 32'(rx), 32'h0ABC);

    // Continuous mode: 32 sclk with cs_n held low, address 2 then 7
    fd_mark = fd_count;
    csLow();
    applyStimulus(16'h1000, 16, -1, '0, rx);
    checkOutput("cont_f1_dout", 32'(rx), 32'h0ABC);
    applyStimulus(16'h3800, 16, -1, '0, rx);
    checkOutput("cont_f2_dout", 32'(rx), 32'h02C3);
    csHigh();
    checkOutput("cont_frame_done", 32'(fd_count - fd_mark), 32'd2);
    checkOutput("cont_cur_ch", 32'(cur_ch), 32'd7);

    // Snapshot: channel 0 changes in the middle of a frame
    csLow(); applyStimulus(16'h0000, 16, -1, '0, rx); csHigh();
    checkOutput("snap_pre_dout", 32'(rx), 32'h07E1);
    setCh(0, 12'h111);
    csLow(); applyStimulus(16'h0000, 16, 6, 12'hFFF, rx); csHigh();
    checkOutput("snap_dout", 32'(rx), 32'h0111);
    csLow(); applyStimulus(16'h1800, 16, -1, '0, rx); csHigh();
    checkOutput("snap_after_dout", 32'(rx), 32'h0FFF);
    checkOutput("snap_cur_ch", 32'(cur_ch), 32'd3);

    // Reset in the middle of a frame that is reading channel 3 (12'h3FF)
    csLow(); applyStimulus(16'h0000, 9, -1, '0, rx);
    repeat (4) @(negedge clk);
    checkOutput("prereset_dout", 32'(dout), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_dout", 32'(dout), 32'd0);
    checkOutput("midreset_cur_ch", 32'(cur_ch), 32'd0);
    checkOutput("midreset_frame_done", 32'(frame_done), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);

    // cs_n is still low after reset, so sclk activity must be ignored
    fd_mark = fd_count;
    applyStimulus(16'h2800, 16, -1, '0, rx);
    checkOutput("postreset_dout", 32'(rx), 32'h0000);
    checkOutput("postreset_frame_done", 32'(fd_count - fd_mark), 32'd0);
    checkOutput("postreset_cur_ch", 32'(cur_ch), 32'd0);
    csHigh();

    // A fresh falling edge of cs_n starts normal frames again
    fd_mark = fd_count;
    csLow(); applyStimulus(16'h0000, 16, -1, '0, rx); csHigh();
    checkOutput("fresh_dout", 32'(rx), 32'h0FFF);
    checkOutput("fresh_frame_done", 32'(fd_count - fd_mark), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
